dac_spi_tx: RTL and testbench
=============================

Name: dac_spi_tx

Overview:
Serial DAC write engine that sits directly downstream of the comparator-threshold DAC value generator. It captures each 16-bit DAC command word on a dac_set request. It then shifts the word MSB-first to the external DAC over a 3-wire SYNC/SCLK/DIN interface. A one-deep pending buffer absorbs requests that arrive during a frame, so threshold updates are never lost, only coalesced.

Parameters:
CLK_DIV, 4, SCLK half-period in clk cycles (>=1); bit period = 2*CLK_DIV
DATA_W, 16, bits per frame
CS_SETUP, 2, clk cycles from SYNC falling to first SCLK falling-phase start (>=1)
CS_HOLD, 2, clk cycles from last SCLK rising edge to SYNC rising (>=1)
CS_IDLE, 4, minimum clk cycles SYNC stays high between frames (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low
dac_value  in  DATA_W  command word to send; sampled only when dac_set=1
dac_set  in  1  write request; level-sampled, every high cycle is one request
dac_sync_n  out  1  DAC frame select, active low
dac_sclk  out  1  serial clock; idle high
dac_din  out  1  serial data; DAC samples on SCLK falling edge
busy  out  1  frame in progress (SETUP through GAP)
done  out  1  one-cycle pulse when a frame completes
overrun  out  1  one-cycle pulse when a pending word is overwritten

Behaviour:
- Reset (async, rst=0): dac_sync_n=1, dac_sclk=1, dac_din=0, busy=0, done=0, overrun=0, pending_valid=0, FSM=IDLE. Reset asserted mid-frame aborts immediately with no partial completion and no done pulse.
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE: if dac_set=1, load dac_value into the shift register, go to SETUP. Next cycle: dac_sync_n=0, busy=1. Latency from request to SYNC low is 1 cycle.
- SETUP: hold for CS_SETUP cycles, then go to SHIFT with dac_din = word[DATA_W-1].
- SHIFT: each bit lasts 2*CLK_DIV cycles.
  - SCLK stays high for CLK_DIV cycles, then low for CLK_DIV cycles.
  - dac_din changes only in the cycle SCLK rises (or at SHIFT entry).
  - Bit counter runs DATA_W-1 down to 0.
  - After bit 0's low phase, SCLK returns high and the FSM goes to HOLD.
- HOLD: hold for CS_HOLD cycles, then go to GAP. In the GAP entry cycle: dac_sync_n=1 and done=1 for 1 cycle.
- GAP: hold for CS_IDLE cycles (SYNC high). On exit:
  - if pending_valid: load pending into the shift register, clear pending_valid, go to SETUP;
  - else: go to IDLE, busy=0.
- SYNC-low duration per frame = CS_SETUP + 2*CLK_DIV*DATA_W + CS_HOLD. Defaults give 132 cycles. Request-to-request throughput at defaults is 136 cycles.
- Requests while busy (SETUP..GAP):
  - pending empty: store dac_value, set pending_valid.
  - pending full: overwrite with the new dac_value, overrun=1 that cycle.
  - The last request always wins.
- A request in the final GAP cycle with pending empty is stored and launches immediately. Same-cycle pending launch and new request: the launched word goes out, and the new request becomes pending (no overrun).
- The in-flight shift register is never modified by a request.
- dac_din = 0 whenever dac_sync_n=1.
- Counters are sized from the parameters via clog2; there is no wrap beyond terminal counts.

Decomposition:
- Shared package scanner_dac_pkg holds:
  - FSM state encoding;
  - DAC frame field positions (bit 15 = update/control flag, bits 11:4 = 8-bit code) for bench checks;
  - default timing constants.
- One sub-module, dac_sclk_gen, owns the half-period counter and bit counter. It emits sclk_rise, sclk_fall and last_bit strobes; the top holds the FSM, shift register and pending buffer.

Test Plan:
- Reset release with dac_set=1, dac_value=16'h07B0 -> SYNC low exactly 132 cycles, 16 falling-edge samples equal 0000_0111_1011_0000, then one done pulse.
- One-cycle dac_set with 16'h89B0 while idle -> dac_sync_n low on the next cycle, first SCLK fall 2+4 cycles later, captured word 16'h89B0.
- During a frame, dac_set with 16'h0890 once -> second frame starts CS_IDLE=4 cycles after SYNC rises, sends 16'h0890, overrun stays 0.
- During a frame, dac_set with 16'h0A10 then 16'h0C80 -> overrun pulses once, the next frame sends 16'h0C80, and 16'h0A10 is never sent.
- rst low at bit 7 of a frame -> outputs at reset values asynchronously, no done; after release, a new request yields a clean full frame.
- Parameter run with CLK_DIV=1, CS_SETUP=CS_HOLD=CS_IDLE=1, word 16'hFFFF -> SYNC low 34 cycles, SCLK toggles every cycle, all 16 bits sampled as 1.

Source files
------------

// File: rtl/scanner_dac_pkg.sv
// ---------------------------------------------------------------------------
// scanner_dac_pkg
// Shared definitions for the serial DAC write path.
//   - dac_state_e : frame engine state encoding
//   - DEF_*       : default timing / width constants
//   - FRAME_*     : field positions inside a DAC command word
//   - frame_code  : extracts the 8-bit threshold code from a command word
// ---------------------------------------------------------------------------
package scanner_dac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } dac_state_e;

    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_CS_SETUP = 2;
    localparam int DEF_CS_HOLD  = 2;
    localparam int DEF_CS_IDLE  = 4;

    // Bit 15 is the DAC update/control flag, bits 11:4 carry the 8-bit code.
    localparam int FRAME_UPDATE_BIT = 15;
    localparam int FRAME_CODE_MSB   = 11;
    localparam int FRAME_CODE_LSB   = 4;

    function automatic logic [7:0] frame_code(input logic [15:0] word);
        return word[FRAME_CODE_MSB:FRAME_CODE_LSB];
    endfunction

endpackage

// File: rtl/dac_spi_tx_if.sv
// ---------------------------------------------------------------------------
// dac_spi_tx_if
// Bundles the request side and the 3-wire DAC side of the write engine.
//   dac_value  : command word, sampled when dac_set is high
//   dac_set    : write request, one request per high cycle
//   dac_sync_n : DAC frame select, active low
//   dac_sclk   : serial clock, idles high
//   dac_din    : serial data, DAC samples on SCLK falling edge
//   busy       : frame in progress
//   done       : one-cycle pulse at frame completion
//   overrun    : one-cycle pulse when a pending word is overwritten
// master = requester (drives dac_value/dac_set), slave = dac_spi_tx.
// ---------------------------------------------------------------------------
interface dac_spi_tx_if
    import scanner_dac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic [DATA_W-1:0] dac_value;
    logic              dac_set;
    logic              dac_sync_n;
    logic              dac_sclk;
    logic              dac_din;
    logic              busy;
    logic              done;
    logic              overrun;

    modport master (
        output dac_value, dac_set,
        input  dac_sync_n, dac_sclk, dac_din, busy, done, overrun
    );

    modport slave (
        input  dac_value, dac_set,
        output dac_sync_n, dac_sclk, dac_din, busy, done, overrun
    );
endinterface

// File: rtl/dac_sclk_gen.sv
// ---------------------------------------------------------------------------
// dac_sclk_gen
// Timing core for the SHIFT phase: half-period counter and bit counter.
//   clk, rst      : system clock, asynchronous active-low reset
//   i_run         : high while the frame engine is in SHIFT; low clears
//                   both counters so every frame starts from bit DATA_W-1
//   o_sclk_fall   : last cycle of a high half-period (SCLK goes low next)
//   o_sclk_rise   : last cycle of a low half-period (SCLK goes high next)
//   o_last_bit    : the bit currently on the wire is bit 0
// ---------------------------------------------------------------------------
module dac_sclk_gen
    import scanner_dac_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    output logic o_sclk_rise,
    output logic o_sclk_fall,
    output logic o_last_bit
);
    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (DATA_W  > 1) ? $clog2(DATA_W)  : 1;

    logic [HW-1:0] r_halfCnt;
    logic          r_lowPhase;
    logic [BW-1:0] r_bitCnt;
    logic          w_halfEnd;

    assign w_halfEnd = (r_halfCnt == HW'(CLK_DIV - 1));

    // The bit counter steps only at the end of a low phase and parks at 0,
    // so it never wraps even if the caller stays in SHIFT one extra cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_halfCnt  <= '0;
            r_lowPhase <= 1'b0;
            r_bitCnt   <= BW'(DATA_W - 1);
        end else if (!i_run) begin
            r_halfCnt  <= '0;
            r_lowPhase <= 1'b0;
            r_bitCnt   <= BW'(DATA_W - 1);
        end else if (w_halfEnd) begin
            r_halfCnt  <= '0;
            r_lowPhase <= ~r_lowPhase;
            if (r_lowPhase && (r_bitCnt != '0)) begin
                r_bitCnt <= r_bitCnt - 1'b1;
            end
        end else begin
            r_halfCnt <= r_halfCnt + 1'b1;
        end
    end

    assign o_sclk_fall = i_run & ~r_lowPhase & w_halfEnd;
    assign o_sclk_rise = i_run &  r_lowPhase & w_halfEnd;
    assign o_last_bit  = (r_bitCnt == '0);

endmodule

// File: rtl/dac_spi_tx.sv
// ---------------------------------------------------------------------------
// dac_spi_tx
// Serial DAC write engine. Captures a command word on each dac_set and
// shifts it MSB-first over SYNC/SCLK/DIN. Requests arriving mid-frame are
// coalesced into a one-deep pending buffer (last request wins).
//   clk, rst : system clock, asynchronous active-low reset
//   bus      : dac_spi_tx_if slave modport (request + DAC pins + status)
// ---------------------------------------------------------------------------
module dac_spi_tx
    import scanner_dac_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int CS_SETUP = DEF_CS_SETUP,
    parameter int CS_HOLD  = DEF_CS_HOLD,
    parameter int CS_IDLE  = DEF_CS_IDLE
) (
    input  logic         clk,
    input  logic         rst,
    dac_spi_tx_if.slave  bus
);
    localparam int CMAX = (CS_SETUP > CS_HOLD) ?
                          ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE) :
                          ((CS_HOLD  > CS_IDLE) ? CS_HOLD  : CS_IDLE);
    localparam int CW   = $clog2(CMAX + 1);

    dac_state_e        r_state;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_pend;
    logic              r_pendValid;
    logic              r_syncN;
    logic              r_sclk;
    logic              r_din;
    logic              r_busy;
    logic              r_done;
    logic              r_overrun;

    logic              w_cntEnd;
    logic              w_sclkRise;
    logic              w_sclkFall;
    logic              w_lastBit;

    dac_sclk_gen #(
        .CLK_DIV (CLK_DIV),
        .DATA_W  (DATA_W)
    ) u_sclk_gen (
        .clk         (clk),
        .rst         (rst),
        .i_run       (r_state == ST_SHIFT),
        .o_sclk_rise (w_sclkRise),
        .o_sclk_fall (w_sclkFall),
        .o_last_bit  (w_lastBit)
    );

    // SETUP, HOLD and GAP share one dwell counter; each state has its own
    // terminal count.
    always_comb begin
        w_cntEnd = 1'b0;
        case (r_state)
            ST_SETUP: w_cntEnd = (r_cnt == CW'(CS_SETUP - 1));
            ST_HOLD:  w_cntEnd = (r_cnt == CW'(CS_HOLD  - 1));
            ST_GAP:   w_cntEnd = (r_cnt == CW'(CS_IDLE  - 1));
            default:  w_cntEnd = 1'b0;
        endcase
    end

    // Frame FSM with registered pin outputs, plus the pending buffer. The
    // final GAP cycle behaves like IDLE for launching, so a waiting word (or
    // a request arriving in that very cycle) starts the next frame with no
    // extra dead cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_pend      <= '0;
            r_pendValid <= 1'b0;
            r_syncN     <= 1'b1;
            r_sclk      <= 1'b1;
            r_din       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_overrun <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (bus.dac_set) begin
                        r_shift <= bus.dac_value;
                        r_state <= ST_SETUP;
                        r_syncN <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                ST_SETUP: begin
                    if (w_cntEnd) begin
                        r_state <= ST_SHIFT;
                        r_din   <= r_shift[DATA_W-1];
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_sclkFall) begin
                        r_sclk <= 1'b0;
                    end else if (w_sclkRise) begin
                        r_sclk <= 1'b1;
                        if (w_lastBit) begin
                            r_state <= ST_HOLD;
                            r_cnt   <= '0;
                        end else begin
                            r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                            r_din   <= r_shift[DATA_W-2];
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_cntEnd) begin
                        r_state <= ST_GAP;
                        r_syncN <= 1'b1;
                        r_din   <= 1'b0;
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (w_cntEnd) begin
                        r_cnt <= '0;
                        if (r_pendValid) begin
                            r_shift <= r_pend;
                            r_state <= ST_SETUP;
                            r_syncN <= 1'b0;
                        end else if (bus.dac_set) begin
                            r_shift <= bus.dac_value;
                            r_state <= ST_SETUP;
                            r_syncN <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // In the launching GAP cycle a new request either becomes the
            // pending word (old pending is being launched, nothing lost) or
            // is itself launched directly, so pending validity is unchanged.
            if ((r_state != ST_IDLE) && bus.dac_set) begin
                r_pend <= bus.dac_value;
                if (!((r_state == ST_GAP) && w_cntEnd)) begin
                    r_pendValid <= 1'b1;
                    r_overrun   <= r_pendValid;
                end
            end else if ((r_state == ST_GAP) && w_cntEnd && r_pendValid) begin
                r_pendValid <= 1'b0;
            end
        end
    end

    assign bus.dac_sync_n = r_syncN;
    assign bus.dac_sclk   = r_sclk;
    assign bus.dac_din    = r_din;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_dac_spi_tx.sv
// ---------------------------------------------------------------------------
// tb_dac_spi_tx
// Drives two engines: one at default timing, one at the fastest timing
// (CLK_DIV=1, all CS_* = 1). A pin-level monitor rebuilds every frame from
// SYNC/SCLK/DIN, and a cycle-arithmetic reference model predicts which
// words go out and when, from request times alone.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dac_spi_tx;
    import scanner_dac_pkg::*;

    localparam int CLK_DIV  = 4;
    localparam int DATA_W   = 16;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_IDLE  = 4;
    localparam int SYNC_LOW = CS_SETUP + 2*CLK_DIV*DATA_W + CS_HOLD;
    localparam int FRAME    = SYNC_LOW + CS_IDLE;
    localparam int F_SYNC_LOW = 1 + 2*DATA_W + 1;

    typedef struct {
        logic [15:0] word;
        int          start;
        int          len;
        int          nbits;
        int          fallOff;
        logic        doneAtEnd;
    } frame_t;

    typedef struct {
        logic [15:0] word;
        int          start;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    int nAsserts = 0;
    int nFails   = 0;

    dac_spi_tx_if #(.DATA_W(DATA_W)) busD();
    dac_spi_tx_if #(.DATA_W(DATA_W)) busF();

    dac_spi_tx #(
        .CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .CS_SETUP(CS_SETUP),
        .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (busD.slave)
    );

    dac_spi_tx #(
        .CLK_DIV(1), .DATA_W(DATA_W), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1)
    ) u_fast (
        .clk (clk),
        .rst (rst),
        .bus (busF.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nAsserts++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Pin-level monitor: rebuilds frames from what the DAC would see.
    frame_t gotQ0[$];
    frame_t gotQ1[$];
    bit     mIn[2];
    logic   mPrevSync[2];
    logic   mPrevSclk[2];
    frame_t mCur[2];
    int     doneCnt[2];
    int     ovCnt[2];
    int     dinErr[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            mIn[i] = 1'b0; mPrevSync[i] = 1'b1; mPrevSclk[i] = 1'b1;
            doneCnt[i] = 0; ovCnt[i] = 0; dinErr[i] = 0;
        end
    end

    task automatic monitorStep(input int id, input logic s, input logic sc, input logic d,
                               input logic dn, input logic ov);
        frame_t f;
        if (!rst) begin
            mIn[id] = 1'b0; mPrevSync[id] = 1'b1; mPrevSclk[id] = 1'b1;
            return;
        end
        f = mCur[id];
        if (mPrevSync[id] && !s) begin
            mIn[id] = 1'b1;
            f.word = '0; f.start = cyc; f.len = 0; f.nbits = 0; f.fallOff = -1; f.doneAtEnd = 1'b0;
        end
        if (!s && mIn[id]) begin
            f.len++;
            if (mPrevSclk[id] && !sc) begin
                f.word = {f.word[14:0], d};
                f.nbits++;
                if (f.fallOff < 0) f.fallOff = cyc - f.start;
            end
        end
        if (!mPrevSync[id] && s && mIn[id]) begin
            f.doneAtEnd = dn;
            if (id == 0) gotQ0.push_back(f); else gotQ1.push_back(f);
            mIn[id] = 1'b0;
        end
        mCur[id] = f;
        if (s && d) dinErr[id]++;
        if (dn) doneCnt[id]++;
        if (ov) ovCnt[id]++;
        mPrevSync[id] = s;
        mPrevSclk[id] = sc;
    endtask

    always @(negedge clk) begin
        monitorStep(0, busD.dac_sync_n, busD.dac_sclk, busD.dac_din, busD.done, busD.overrun);
        monitorStep(1, busF.dac_sync_n, busF.dac_sclk, busF.dac_din, busF.done, busF.overrun);
    end

    // Reference model: a frame launched in cycle L holds SYNC low from L+1
    // and can hand over to the next word in cycle L+FRAME. Requests between
    // those points collapse into a single pending word.
    exp_t        expQ[$];
    bit          mBusy = 1'b0;
    int          mDecision = 0;
    bit          mPendValid = 1'b0;
    logic [15:0] mPend = '0;
    int          expOverrun = 0;
    int          expDone = 0;
    logic [15:0] lastGotWord = '0;

    task automatic launch(input logic [15:0] w);
        exp_t e;
        e.word  = w;
        e.start = cyc + 1;
        expQ.push_back(e);
        mBusy     = 1'b1;
        mDecision = cyc + FRAME;
    endtask

    task automatic modelStep(input bit set, input logic [15:0] v);
        if (!mBusy) begin
            if (set) launch(v);
        end else if (cyc == mDecision) begin
            if (mPendValid) begin
                launch(mPend);
                mPendValid = set;
                if (set) mPend = v;
            end else if (set) begin
                launch(v);
            end else begin
                mBusy = 1'b0;
            end
        end else if (set) begin
            if (mPendValid) expOverrun++;
            mPend      = v;
            mPendValid = 1'b1;
        end
    endtask

    // One clock of stimulus on the default engine; returns 1 ns after the
    // edge that sampled it.
    task automatic applyStimulus(input bit set, input logic [15:0] v);
        busD.dac_set   = set;
        busD.dac_value = v;
        modelStep(set, v);
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 16'($urandom));
    endtask

    task automatic runToDecision();
        for (int i = 0; i < 2*FRAME && cyc != mDecision; i++) applyStimulus(1'b0, 16'($urandom));
        checkOutput("reach_decision", cyc, mDecision);
    endtask

    task automatic compareFrames(input string tag);
        exp_t   e;
        frame_t f;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            if (gotQ0.size() == 0) begin
                checkOutput({tag, "_frame_present"}, 0, 1);
            end else begin
                f = gotQ0.pop_front();
                lastGotWord = f.word;
                expDone++;
                checkOutput({tag, "_word"},     f.word,      e.word);
                checkOutput({tag, "_start"},    f.start,     e.start);
                checkOutput({tag, "_sync_len"}, f.len,       SYNC_LOW);
                checkOutput({tag, "_nbits"},    f.nbits,     DATA_W);
                checkOutput({tag, "_first_fall"}, f.fallOff, CS_SETUP + CLK_DIV);
                checkOutput({tag, "_done_at_end"}, f.doneAtEnd, 1);
            end
        end
        checkOutput({tag, "_extra_frames"}, gotQ0.size(), 0);
        checkOutput({tag, "_done_count"},   doneCnt[0], expDone);
        checkOutput({tag, "_overrun_count"}, ovCnt[0],  expOverrun);
        checkOutput({tag, "_din_idle_zero"}, dinErr[0], 0);
    endtask

    initial begin
        int          frameStart;
        int          doneBefore;
        int          reqCyc;
        frame_t      ff;

        busD.dac_set = 1'b0; busD.dac_value = '0;
        busF.dac_set = 1'b0; busF.dac_value = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset values
        checkOutput("rst_sync_n",  busD.dac_sync_n, 1);
        checkOutput("rst_sclk",    busD.dac_sclk,   1);
        checkOutput("rst_din",     busD.dac_din,    0);
        checkOutput("rst_busy",    busD.busy,       0);
        checkOutput("rst_done",    busD.done,       0);
        checkOutput("rst_overrun", busD.overrun,    0);

        // Request already high at reset release
        rst = 1'b1;
        applyStimulus(1'b1, 16'h07B0);
        idleCycles(2*FRAME + 10);
        compareFrames("t1");
        checkOutput("t1_update_flag", lastGotWord[FRAME_UPDATE_BIT], 0);
        checkOutput("t1_code", frame_code(lastGotWord), 8'h7B);

        // Single request from idle: SYNC low on the next cycle
        applyStimulus(1'b1, 16'h89B0);
        checkOutput("t2_sync_latency", busD.dac_sync_n, 0);
        checkOutput("t2_busy", busD.busy, 1);
        idleCycles(2*FRAME + 10);
        compareFrames("t2");
        checkOutput("t2_idle_busy", busD.busy, 0);

        // One request during a frame becomes the next frame
        applyStimulus(1'b1, 16'h1234);
        idleCycles(30);
        applyStimulus(1'b1, 16'h0890);
        idleCycles(2*FRAME + 10);
        compareFrames("t3");

        // Two requests during a frame: the later one wins
        applyStimulus(1'b1, 16'h5555);
        idleCycles(20);
        applyStimulus(1'b1, 16'h0A10);
        idleCycles(40);
        applyStimulus(1'b1, 16'h0C80);
        idleCycles(2*FRAME + 10);
        compareFrames("t4");

        // Request in the final GAP cycle with nothing pending
        applyStimulus(1'b1, 16'h3C3C);
        runToDecision();
        applyStimulus(1'b1, 16'hA5A5);
        idleCycles(2*FRAME + 10);
        compareFrames("t5");

        // Pending launch and a new request in the same cycle
        applyStimulus(1'b1, 16'h1111);
        idleCycles(10);
        applyStimulus(1'b1, 16'h2222);
        runToDecision();
        applyStimulus(1'b1, 16'h3333);
        idleCycles(3*FRAME + 10);
        compareFrames("t6");

        // Randomized request traffic
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0), 16'($urandom));
        end
        idleCycles(2*FRAME + 10);
        compareFrames("t7");

        // Reset during bit 7 aborts the frame without a done pulse
        applyStimulus(1'b1, 16'hC3A5);
        frameStart = cyc;
        idleCycles(CS_SETUP + (DATA_W - 1 - 7) * 2 * CLK_DIV + 2);
        doneBefore = doneCnt[0];
        rst = 1'b0;
        #1;
        checkOutput("t8_sync_n", busD.dac_sync_n, 1);
        checkOutput("t8_sclk",   busD.dac_sclk,   1);
        checkOutput("t8_din",    busD.dac_din,    0);
        checkOutput("t8_busy",   busD.busy,       0);
        expQ.delete();
        mBusy = 1'b0; mPendValid = 1'b0;
        busD.dac_set = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t8_no_done",   doneCnt[0],   doneBefore);
        checkOutput("t8_no_frame",  gotQ0.size(), 0);
        checkOutput("t8_started",   (frameStart > 0), 1);
        rst = 1'b1;
        applyStimulus(1'b1, 16'h0F0F);
        idleCycles(2*FRAME + 10);
        compareFrames("t8");

        // Fastest timing engine
        busF.dac_set = 1'b1; busF.dac_value = 16'hFFFF;
        reqCyc = cyc;
        applyStimulus(1'b0, 16'h0000);
        busF.dac_set = 1'b0;
        idleCycles(60);
        checkOutput("t9_frames", gotQ1.size(), 1);
        if (gotQ1.size() > 0) begin
            ff = gotQ1.pop_front();
            checkOutput("t9_word",       ff.word,      16'hFFFF);
            checkOutput("t9_start",      ff.start,     reqCyc + 1);
            checkOutput("t9_sync_len",   ff.len,       F_SYNC_LOW);
            checkOutput("t9_nbits",      ff.nbits,     DATA_W);
            checkOutput("t9_first_fall", ff.fallOff,   2);
            checkOutput("t9_done",       ff.doneAtEnd, 1);
        end
        checkOutput("t9_overrun", ovCnt[1], 0);
        checkOutput("t9_din_idle_zero", dinErr[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
